// File: rtl/pio_pkg.sv
// Shared encodings for the PIO sequencing test master: TLP types, completion
// types, failure codes and controller states.
package pio_pkg;

  localparam logic [2:0] TX_TYPE_MEMRD32 = 3'd0;
  localparam logic [2:0] TX_TYPE_MEMWR32 = 3'd1;
  localparam logic [2:0] TX_TYPE_MEMRD64 = 3'd2;
  localparam logic [2:0] TX_TYPE_MEMWR64 = 3'd3;
  localparam logic [2:0] TX_TYPE_IORD    = 3'd4;
  localparam logic [2:0] TX_TYPE_IOWR    = 3'd5;

  localparam logic RX_TYPE_CPL  = 1'b0;
  localparam logic RX_TYPE_CPLD = 1'b1;

  localparam logic [1:0] FAIL_NONE    = 2'd0;
  localparam logic [1:0] FAIL_CONFIG  = 2'd1;
  localparam logic [1:0] FAIL_BAD_CPL = 2'd2;
  localparam logic [1:0] FAIL_TIMEOUT = 2'd3;

  typedef enum logic [3:0] {
    ST_WAIT_CFG,
    ST_WRITE,
    ST_WRITE_WAIT,
    ST_READ,
    ST_READ_WAIT,
    ST_CPL_WAIT,
    ST_NEXT,
    ST_DONE,
    ST_ERROR
  } pio_state_e;

  // Payload of transfer idx: the index byte replicated across the word, added to the seed.
  function automatic logic [31:0] pio_xfer_data(input logic [31:0] seed, input logic [7:0] idx);
    return seed + {4{idx}};
  endfunction

endpackage

// File: rtl/pio_cpl_timer.sv
// Completion watchdog: counts enabled cycles from a clear and flags expiry
// on the cycle the count reaches CPL_TIMEOUT-1.
module pio_cpl_timer #(
  parameter int CPL_TIMEOUT = 1024
) (
  input  logic user_clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CNT_W = $clog2(CPL_TIMEOUT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CPL_TIMEOUT - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign expire = enable && (count_q == LAST_CNT);

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expire) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge user_clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/pio_seq_controller.sv
// Root-port PIO test master: after configuration, issues NUM_XFERS strided
// write/read-back pairs, checks each completion and reports the outcome.
module pio_seq_controller
  import pio_pkg::*;
#(
  parameter int          TCQ         = 1,
  parameter int          NUM_XFERS   = 4,
  parameter logic [63:0] ADDR_BASE   = 64'h8000_0000,
  parameter int          ADDR_STRIDE = 4,
  parameter int          FORCE_64BIT = 0,
  parameter logic [31:0] DATA_SEED   = 32'h1234_5678,
  parameter int          CPL_TIMEOUT = 1024
) (
  input  logic        user_clk,
  input  logic        reset,
  input  logic        user_lnk_up,
  input  logic        test_restart,
  output logic        test_finished,
  output logic        test_failed,
  output logic        start_config,
  input  logic        finished_config,
  input  logic        failed_config,
  output logic [2:0]  tx_type,
  output logic [7:0]  tx_tag,
  output logic [63:0] tx_addr,
  output logic [31:0] tx_data,
  output logic        tx_start,
  input  logic        tx_done,
  output logic        rx_type,
  output logic [7:0]  rx_tag,
  output logic [31:0] rx_data,
  input  logic        rx_good,
  input  logic        rx_bad,
  input  logic [7:0]  addr_offset,
  output logic [7:0]  xfer_idx,
  output logic [1:0]  fail_code
);

  localparam logic [7:0] LAST_IDX = 8'(NUM_XFERS - 1);

  // TCQ is a simulation-only clock-to-q delay; synthesizable flops carry no delay.
  logic tcq_unused;
  assign tcq_unused = (TCQ != 0);

  pio_state_e  state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  tag_q, tag_d;
  logic        tx_start_q, tx_start_d;
  logic [2:0]  tx_type_q, tx_type_d;
  logic [63:0] tx_addr_q, tx_addr_d;
  logic [31:0] tx_data_q, tx_data_d;
  logic [31:0] rx_data_q, rx_data_d;
  logic        rx_type_q, rx_type_d;
  logic [1:0]  fail_code_q, fail_code_d;
  logic        finished_q, failed_q;
  logic        lnk_q, lnk_q2;

  logic        timer_clear;
  logic        timer_en;
  logic        timer_expire;
  logic [63:0] xfer_addr;
  logic        xfer_wide;
  logic [31:0] xfer_data;

  assign xfer_addr = ADDR_BASE + {56'd0, addr_offset} + (64'(idx_q) * 64'(ADDR_STRIDE));
  assign xfer_wide = (FORCE_64BIT != 0) || (xfer_addr[63:32] != 32'd0);
  assign xfer_data = pio_xfer_data(DATA_SEED, idx_q);
  assign timer_en  = (state_q == ST_CPL_WAIT);

  pio_cpl_timer #(
    .CPL_TIMEOUT (CPL_TIMEOUT)
  ) u_cpl_timer (
    .user_clk (user_clk),
    .reset    (reset),
    .clear    (timer_clear),
    .enable   (timer_en),
    .expire   (timer_expire)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    tag_d       = tag_q;
    tx_start_d  = 1'b0;
    tx_type_d   = tx_type_q;
    tx_addr_d   = tx_addr_q;
    tx_data_d   = tx_data_q;
    rx_data_d   = rx_data_q;
    rx_type_d   = rx_type_q;
    fail_code_d = fail_code_q;
    timer_clear = 1'b0;

    if (!user_lnk_up) begin
      state_d = ST_WAIT_CFG;
      idx_d   = '0;
    end else begin
      case (state_q)
        ST_WAIT_CFG: begin
          if (failed_config) begin
            state_d     = ST_ERROR;
            fail_code_d = FAIL_CONFIG;
          end else if (finished_config) begin
            state_d = ST_WRITE;
            idx_d   = '0;
          end
        end
        ST_WRITE, ST_READ: begin
          tx_start_d = 1'b1;
          tag_d      = tag_q + 8'd1;
          tx_addr_d  = xfer_addr;
          tx_data_d  = xfer_data;
          rx_data_d  = xfer_data;
          if (state_q == ST_WRITE) begin
            tx_type_d = xfer_wide ? TX_TYPE_MEMWR64 : TX_TYPE_MEMWR32;
            rx_type_d = RX_TYPE_CPL;
            state_d   = ST_WRITE_WAIT;
          end else begin
            tx_type_d = xfer_wide ? TX_TYPE_MEMRD64 : TX_TYPE_MEMRD32;
            rx_type_d = RX_TYPE_CPLD;
            state_d   = ST_READ_WAIT;
          end
        end
        ST_WRITE_WAIT: begin
          if (tx_done) state_d = ST_READ;
        end
        ST_READ_WAIT: begin
          if (tx_done) begin
            state_d     = ST_CPL_WAIT;
            timer_clear = 1'b1;
          end
        end
        ST_CPL_WAIT: begin
          // A mismatch outranks a match seen in the same cycle; both outrank the watchdog.
          if (rx_bad) begin
            state_d     = ST_ERROR;
            fail_code_d = FAIL_BAD_CPL;
          end else if (rx_good) begin
            state_d = ST_NEXT;
          end else if (timer_expire) begin
            state_d     = ST_ERROR;
            fail_code_d = FAIL_TIMEOUT;
          end
        end
        ST_NEXT: begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = ST_WRITE;
          end
        end
        ST_DONE, ST_ERROR: begin
          if (test_restart) begin
            state_d     = ST_WAIT_CFG;
            fail_code_d = FAIL_NONE;
            idx_d       = '0;
          end
        end
        default: state_d = ST_WAIT_CFG;
      endcase
    end
  end

  always_ff @(posedge user_clk) begin
    if (reset) begin
      state_q     <= ST_WAIT_CFG;
      idx_q       <= '0;
      tag_q       <= '0;
      tx_start_q  <= 1'b0;
      tx_type_q   <= '0;
      tx_addr_q   <= '0;
      tx_data_q   <= '0;
      rx_data_q   <= '0;
      rx_type_q   <= 1'b0;
      fail_code_q <= FAIL_NONE;
      finished_q  <= 1'b0;
      failed_q    <= 1'b0;
      lnk_q       <= 1'b0;
      lnk_q2      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      tag_q       <= tag_d;
      tx_start_q  <= tx_start_d;
      tx_type_q   <= tx_type_d;
      tx_addr_q   <= tx_addr_d;
      tx_data_q   <= tx_data_d;
      rx_data_q   <= rx_data_d;
      rx_type_q   <= rx_type_d;
      fail_code_q <= fail_code_d;
      finished_q  <= (state_q == ST_DONE);
      failed_q    <= (state_q == ST_ERROR);
      lnk_q       <= user_lnk_up;
      lnk_q2      <= lnk_q;
    end
  end

  assign start_config  = lnk_q & ~lnk_q2;
  assign test_finished = finished_q;
  assign test_failed   = failed_q;
  assign tx_type       = tx_type_q;
  assign tx_tag        = tag_q;
  assign rx_tag        = tag_q;
  assign tx_addr       = tx_addr_q;
  assign tx_data       = tx_data_q;
  assign tx_start      = tx_start_q;
  assign rx_type       = rx_type_q;
  assign rx_data       = rx_data_q;
  assign xfer_idx      = idx_q;
  assign fail_code     = fail_code_q;

endmodule

// File: tb/tb_pio_seq_controller.sv
// Directed-sequence bench with randomized offsets/delays for pio_seq_controller,
// checked against an arithmetic model of the transfer rules.
module tb_pio_seq_controller;
  import pio_pkg::*;

  localparam int          NX     = 4;
  localparam logic [63:0] BASE   = 64'hFFFF_FFF0;
  localparam int          STRIDE = 4;
  localparam logic [31:0] SEED   = 32'h1234_5678;
  localparam int          TMO    = 16;

  logic        user_clk = 1'b0;
  logic        reset = 1'b1;
  logic        user_lnk_up = 1'b0;
  logic        test_restart = 1'b0;
  logic        finished_config = 1'b0;
  logic        failed_config = 1'b0;
  logic        tx_done = 1'b0;
  logic        rx_good = 1'b0;
  logic        rx_bad = 1'b0;
  logic [7:0]  addr_offset = 8'd0;
  logic        test_finished, test_failed, start_config, tx_start, rx_type;
  logic [2:0]  tx_type;
  logic [7:0]  tx_tag, rx_tag, xfer_idx;
  logic [63:0] tx_addr;
  logic [31:0] tx_data, rx_data;
  logic [1:0]  fail_code;

  always #5 user_clk = ~user_clk;

  pio_seq_controller #(
    .TCQ(1), .NUM_XFERS(NX), .ADDR_BASE(BASE), .ADDR_STRIDE(STRIDE),
    .FORCE_64BIT(0), .DATA_SEED(SEED), .CPL_TIMEOUT(TMO)
  ) dut (
    .user_clk(user_clk), .reset(reset), .user_lnk_up(user_lnk_up),
    .test_restart(test_restart), .test_finished(test_finished), .test_failed(test_failed),
    .start_config(start_config), .finished_config(finished_config), .failed_config(failed_config),
    .tx_type(tx_type), .tx_tag(tx_tag), .tx_addr(tx_addr), .tx_data(tx_data),
    .tx_start(tx_start), .tx_done(tx_done), .rx_type(rx_type), .rx_tag(rx_tag),
    .rx_data(rx_data), .rx_good(rx_good), .rx_bad(rx_bad), .addr_offset(addr_offset),
    .xfer_idx(xfer_idx), .fail_code(fail_code)
  );

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_tag = 8'd0;
  int         tags_issued = 0;
  bit         wrap_seen = 1'b0;

  // Reference model: plain arithmetic on the transfer rules.
  function automatic logic [63:0] m_addr(input int idx, input logic [7:0] off);
    return BASE + 64'(off) + 64'(idx) * 64'(STRIDE);
  endfunction

  function automatic logic [31:0] m_data(input int idx);
    return SEED + 32'(idx) * 32'h0101_0101;
  endfunction

  function automatic logic [2:0] m_type(input bit is_wr, input logic [63:0] a);
    bit wide;
    wide = (a >= 64'h1_0000_0000);
    if (is_wr) return wide ? 3'd3 : 3'd1;
    return wide ? 3'd2 : 3'd0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge user_clk);
    #1;
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick;
      if (tx_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    chk("tx_start_seen", 64'(ok), 64'd1);
  endtask

  task automatic wait_end(output int starts);
    starts = 0;
    for (int i = 0; i < 40; i++) begin
      tick;
      if (tx_start === 1'b1) starts++;
      if (test_finished === 1'b1 || test_failed === 1'b1) break;
    end
  endtask

  task automatic pulse_done;
    tx_done = 1'b1;
    tick;
    tx_done = 1'b0;
  endtask

  task automatic pulse_config;
    finished_config = 1'b1;
    tick;
    finished_config = 1'b0;
  endtask

  task automatic check_tx(input bit is_wr, input int idx, input logic [7:0] off);
    logic [63:0] a;
    a = m_addr(idx, off);
    exp_tag = exp_tag + 8'd1;
    tags_issued++;
    if (exp_tag == 8'd0 && tx_tag === 8'd0) wrap_seen = 1'b1;
    chk("tx_type", 64'(tx_type), 64'(m_type(is_wr, a)));
    chk("tx_addr", tx_addr, a);
    chk("tx_tag", 64'(tx_tag), 64'(exp_tag));
    chk("rx_tag", 64'(rx_tag), 64'(exp_tag));
    chk("rx_type", 64'(rx_type), 64'(is_wr ? 0 : 1));
    chk("xfer_idx", 64'(xfer_idx), 64'(idx));
    chk("tx_data", 64'(tx_data), 64'(m_data(idx)));
    chk("rx_data", 64'(rx_data), 64'(m_data(idx)));
  endtask

  // mode 0: good completion, 1: bad completion, 2: no completion, 3: drop link in READ_WAIT
  task automatic do_pair(input int idx, input logic [7:0] off, input int mode);
    bit ok;
    int n;
    wait_start(ok);
    if (!ok) return;
    check_tx(1'b1, idx, off);
    tick;
    chk("tx_start_width", 64'(tx_start), 64'd0);
    if ($urandom_range(0, 1) == 1) begin
      rx_bad = 1'b1;
      rx_good = 1'b1;
      tick;
      rx_bad = 1'b0;
      rx_good = 1'b0;
    end
    repeat ($urandom_range(0, 3)) tick;
    pulse_done;
    wait_start(ok);
    if (!ok) return;
    check_tx(1'b0, idx, off);
    if (mode == 3) begin
      user_lnk_up = 1'b0;
      tick;
      chk("drop_idx", 64'(xfer_idx), 64'd0);
      chk("drop_tx_start", 64'(tx_start), 64'd0);
      return;
    end
    repeat ($urandom_range(1, 3)) tick;
    pulse_done;
    if (mode == 0) begin
      repeat ($urandom_range(0, 6)) tick;
      rx_good = 1'b1;
      tick;
      rx_good = 1'b0;
    end else if (mode == 1) begin
      repeat ($urandom_range(0, 6)) tick;
      rx_bad = 1'b1;
      tick;
      rx_bad = 1'b0;
    end else begin
      n = 0;
      for (int i = 0; i < 40; i++) begin
        if (test_failed === 1'b1) break;
        tick;
        n++;
      end
      // ERROR is entered TMO cycles after tx_done; the registered flag shows one cycle later.
      chk("timeout_cycles", 64'(n), 64'(TMO + 1));
    end
  endtask

  task automatic link_check;
    int k;
    bit seen;
    k = 0;
    seen = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick;
      if (start_config === 1'b1) begin
        k = i;
        seen = 1'b1;
        break;
      end
    end
    chk("cfg_pulse_seen", 64'(seen), 64'd1);
    chk("cfg_pulse_latency", 64'(k >= 1 && k <= 2), 64'd1);
    tick;
    chk("cfg_pulse_width", 64'(start_config), 64'd0);
  endtask

  task automatic restart;
    test_restart = 1'b1;
    tick;
    test_restart = 1'b0;
    tick;
    chk("restart_finished", 64'(test_finished), 64'd0);
    chk("restart_failed", 64'(test_failed), 64'd0);
    chk("restart_code", 64'(fail_code), 64'd0);
    chk("restart_idx", 64'(xfer_idx), 64'd0);
  endtask

  task automatic run_good(input logic [7:0] off);
    int starts;
    addr_offset = off;
    pulse_config;
    for (int i = 0; i < NX; i++) do_pair(i, off, 0);
    wait_end(starts);
    chk("run_finished", 64'(test_finished), 64'd1);
    chk("run_failed", 64'(test_failed), 64'd0);
    chk("run_code", 64'(fail_code), 64'd0);
    chk("run_last_idx", 64'(xfer_idx), 64'(NX - 1));
  endtask

  initial begin
    int starts;
    logic [7:0] off;

    // Reset values
    repeat (3) tick;
    chk("rst_tx_start", 64'(tx_start), 64'd0);
    chk("rst_tx_tag", 64'(tx_tag), 64'd0);
    chk("rst_tx_addr", tx_addr, 64'd0);
    chk("rst_tx_data", 64'(tx_data), 64'd0);
    chk("rst_rx_data", 64'(rx_data), 64'd0);
    chk("rst_tx_type", 64'(tx_type), 64'd0);
    chk("rst_rx_type", 64'(rx_type), 64'd0);
    chk("rst_finished", 64'(test_finished), 64'd0);
    chk("rst_failed", 64'(test_failed), 64'd0);
    chk("rst_start_config", 64'(start_config), 64'd0);
    chk("rst_xfer_idx", 64'(xfer_idx), 64'd0);
    chk("rst_fail_code", 64'(fail_code), 64'd0);
    reset = 1'b0;
    user_lnk_up = 1'b1;
    link_check;

    // Full run straddling the 4 GiB boundary: 32-bit then 64-bit types
    run_good(8'h08);

    // Bad completion on the second read
    restart;
    off = 8'($urandom_range(0, 255));
    addr_offset = off;
    pulse_config;
    do_pair(0, off, 0);
    do_pair(1, off, 1);
    wait_end(starts);
    chk("bad_failed", 64'(test_failed), 64'd1);
    chk("bad_code", 64'(fail_code), 64'd2);
    chk("bad_idx", 64'(xfer_idx), 64'd1);

    // No completion at all
    restart;
    pulse_config;
    do_pair(0, off, 2);
    chk("tmo_failed", 64'(test_failed), 64'd1);
    chk("tmo_code", 64'(fail_code), 64'd3);

    // Configurator reports both success and failure together
    restart;
    failed_config = 1'b1;
    finished_config = 1'b1;
    tick;
    failed_config = 1'b0;
    finished_config = 1'b0;
    wait_end(starts);
    chk("cfg_failed", 64'(test_failed), 64'd1);
    chk("cfg_code", 64'(fail_code), 64'd1);
    chk("cfg_no_tx", 64'(starts), 64'd0);

    // Link drop while waiting on a read, then relink and rerun
    restart;
    off = 8'($urandom_range(0, 255));
    addr_offset = off;
    pulse_config;
    do_pair(0, off, 0);
    do_pair(1, off, 0);
    do_pair(2, off, 3);
    tx_done = 1'b1;
    rx_good = 1'b1;
    tick;
    tx_done = 1'b0;
    rx_good = 1'b0;
    starts = 0;
    repeat (3) begin
      tick;
      if (tx_start === 1'b1) starts++;
    end
    chk("down_no_tx", 64'(starts), 64'd0);
    chk("down_finished", 64'(test_finished), 64'd0);
    user_lnk_up = 1'b1;
    link_check;
    run_good(8'($urandom_range(0, 255)));

    // Keep rerunning until the tag counter has wrapped
    while (tags_issued < 264) begin
      restart;
      run_good(8'($urandom_range(0, 255)));
    end
    chk("tag_wrap_seen", 64'(wrap_seen), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
